// File: rtl/fib_pkg.sv
// Shared constants and helpers for the Fibonacci pair serializer.
// Default word width, buffer depth and pointer width function.
package fib_pkg;

  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fib_pair_fifo.sv
// Pair buffer: DEPTH entries of DW bits, valid/ready on both sides.
// Ready only when not full; a pop never frees space in the same cycle.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int DW    = 2 * W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   cnt;
  logic          alive;
  logic          push;
  logic          pop;

  assign in_ready  = alive && (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers wrap naturally; occupancy tracks full vs empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else begin
      alive <= 1'b1;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// Buffers (num, num2) pairs and streams them out as single words,
// checking that each word is the sum of the previous two.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         err,
  output logic [7:0]   err_cnt
);

  logic [2*W-1:0] head;
  logic           f_valid;
  logic           f_ready;
  logic           half;
  logic           acc;
  logic [W-1:0]   h0;
  logic [W-1:0]   h1;
  logic [1:0]     hcnt;
  logic [W-1:0]   sum;
  logic           bad;

  fib_pair_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_num, in_num2}),
    .out_valid (f_valid),
    .out_ready (f_ready),
    .out_data  (head)
  );

  assign f_ready   = out_ready && half;
  assign out_valid = f_valid;
  assign out_data  = !f_valid ? '0
                   : half ? head[W-1:0]
                   : head[2*W-1:W];
  assign acc = f_valid && out_ready;
  assign sum = h0 + h1;
  assign bad = acc && (hcnt == 2'd2) && (out_data != sum);

  // Half-select toggles per accepted word; pair pops on num2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) half <= 1'b0;
    else if (acc) half <= ~half;
  end

  // Recurrence checker keeps the actual words, even after a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0      <= '0;
      h1      <= '0;
      hcnt    <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (acc) begin
      h0 <= out_data;
      h1 <= h0;
      if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
      if (bad) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/fib_pair_serializer.md
FIB_PAIR_SERIALIZER -- requirements
Module: fib_pair_serializer

Interface
REQ-001 SHALL have parameter W, default 16: width of each data word.
REQ-002 SHALL have parameter DEPTH, default 4: number of pair entries in the buffer, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream pair valid.
REQ-006 SHALL have port in_ready, output, 1: buffer can accept a pair.
REQ-007 SHALL have port in_num, input, W: first (older) word of the pair.
REQ-008 SHALL have port in_num2, input, W: second (newer) word of the pair.
REQ-009 SHALL have port out_valid, output, 1: out_data valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-011 SHALL have port out_data, output, W: serialized word stream.
REQ-012 SHALL have port err, output, 1: sticky recurrence-violation flag.
REQ-013 SHALL have port err_cnt, output, 8: recurrence-violation count, saturating.

Function
REQ-014 SHALL accept a pair on a clock edge where in_valid and in_ready are both 1, and only then.
REQ-015 SHALL drive in_ready = 1 exactly when fewer than DEPTH pairs are stored; no full-bypass, so a pop and a push in the same cycle while full SHALL NOT accept the push.
REQ-016 SHALL emit each pair as two words, in_num first, then in_num2, preserving pair arrival order.
REQ-017 SHALL have latency of one cycle: a pair accepted at edge N SHALL make out_valid 1 after edge N when the buffer was empty. There is no combinational in-to-out path.
REQ-018 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL keep a half-select bit: 0 selects the head word num, 1 selects num2.
REQ-020 SHALL advance the half-select bit on each accepted output word.
REQ-021 SHALL pop the head pair and clear the half-select bit when the num2 word is accepted.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; the full/empty distinction uses an occupancy counter of width log2(DEPTH)+1.
REQ-023 SHALL support a simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-024 SHALL track the last two accepted output words and a saturating accepted-word count (0..2).
REQ-025 SHALL, from the third accepted word onward, compare each accepted word with the sum of the previous two, truncated to W bits (mod 2^W).
REQ-026 SHALL, on a mismatch, set err to 1 on the edge after acceptance and increment err_cnt, saturating at 255.
REQ-027 SHALL NOT resynchronize the checker history after a mismatch; the actual received words enter the history.

Reset
REQ-028 SHALL, while rst_n = 0, force in_ready = 0, out_valid = 0, out_data = 0, err = 0 and err_cnt = 0.
REQ-029 SHALL, while rst_n = 0, clear the pointers, occupancy, half-select, checker history and checker count.
REQ-030 SHALL raise in_ready to 1 on the first edge after rst_n deasserts.
REQ-031 SHALL discard all stored pairs and checker history when reset is asserted mid-operation; buffer memory contents need not be cleared.

Structure
REQ-032 SHALL take the default W and DEPTH constants and a function for the pointer width from shared package fib_pkg.
REQ-033 SHALL implement the buffer as sub-module fib_pair_fifo (2*W wide, DEPTH deep, valid/ready on both sides).
REQ-034 SHALL implement the serializer and checker in the top module.

Verification
REQ-035 SHALL cover reset: rst_n = 0 -> in_ready = 0, out_valid = 0, err = 0, err_cnt = 0; first edge after release -> in_ready = 1.
REQ-036 SHALL cover streaming: pairs (1,1), (2,3), (5,8), out_ready = 1 -> out_data 1, 1, 2, 3, 5, 8 on consecutive cycles, err = 0.
REQ-037 SHALL cover backpressure: out_ready = 0, push pairs (1,1), (2,3), (5,8), (13,21) -> in_ready = 0 after the 4th; 5th pair (34,55) held; all 10 words then drain in order.
REQ-038 SHALL cover a recurrence violation: (1,1), (2,3), (5,8), (13,22) -> err = 1 and err_cnt = 1 after 22 is accepted; err stays 1 for the rest of the run.
REQ-039 SHALL cover wrap-around arithmetic: words 28657, 46368, 9489 (75025 mod 65536) -> err stays 0.
REQ-040 SHALL cover reset mid-stream: assert rst_n = 0 with 3 pairs buffered and err = 1 -> after release, out_valid = 0, err = 0, err_cnt = 0; a new sequence (1,1), (2,3) outputs 1, 1, 2, 3 with no error.
